mul_seq_32: RTL
===============

MUL_SEQ_32 -- requirements
Module: mul_seq_32

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port start, input, 1 bit: request to begin a multiply, sampled each rising edge.
REQ-005 Port a, input, 32 bits: unsigned multiplicand, sampled only on an accepted start.
REQ-006 Port b, input, 32 bits: unsigned multiplier, sampled only on an accepted start.
REQ-007 Port busy, output, 1 bit: high while in state RUN.
REQ-008 Port done, output, 1 bit: one-cycle pulse when the product register is updated.
REQ-009 Port product, output, 64 bits: last completed a*b, held stable between completions.

Function
REQ-010 The block SHALL use the states IDLE, RUN and DONE.
REQ-011 Start SHALL be accepted on a rising edge where start=1 and the state is IDLE or DONE.
REQ-012 An accepted start SHALL load the internal registers as follows: mcand = {32'b0,a}, mplier = b, acc = 0, cnt = 0; state goes to RUN.
REQ-013 Each RUN cycle SHALL do the following:
- if mplier[0]=1, then acc <= acc + mcand, computed through the 64-bit adder; otherwise acc holds.
- mcand <= mcand << 1.
- mplier <= mplier >> 1.
- cnt <= cnt + 1.
REQ-014 RUN SHALL last exactly 32 cycles; on the edge where cnt=31, product <= final acc value and state goes to DONE.
REQ-015 The adder carry-out SHALL be ignored; a 32x32 unsigned product cannot exceed 64 bits.
REQ-016 done SHALL be 1 only in DONE, for exactly one cycle per completed operation.
REQ-017 Latency: for start accepted at edge E, done=1 and product is valid in the cycle following edge E+32.
REQ-018 From DONE, the state SHALL go to RUN if start=1 (back-to-back accept); otherwise it goes to IDLE.
REQ-019 start during RUN SHALL be ignored, with no effect on operands, counter or product.
REQ-020 product SHALL change only at completion (REQ-014) or on reset, never during RUN.
REQ-021 busy SHALL be 0 in IDLE and DONE, and 1 in RUN.
REQ-022 a and b SHALL be don't-care except on the accept edge.

Reset
REQ-023 rst=1 SHALL take priority over start and over any state transition.
REQ-024 On reset, the following SHALL be cleared: state to IDLE, busy=0, done=0, product=0, and acc, mcand, mplier and cnt to 0.
REQ-025 Reset during RUN SHALL abort the operation: no done pulse, and product reads 0.

Structure
REQ-026 The shared package SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the operand width constant (32) and the iteration count constant (32).
REQ-027 The block SHALL instantiate one sub-module, fulladd_64, for the acc+mcand add; no other arithmetic sub-modules are permitted.
REQ-028 cnt SHALL be 5 bits wide; its wrap from 31 to 0 SHALL NOT be relied upon for the state change, which is decoded from cnt=31.

Verification
REQ-029 Basic multiply: a=3, b=5, start for 1 cycle -> busy for 32 cycles, then done for 1 cycle with product=64'd15.
REQ-030 Maximum operands: a=b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001, done exactly 33 cycles after the accept edge.
REQ-031 Zero and mid operands: a=0, b=32'h1234_5678 -> product=0; then a=32'h0001_0000, b=32'h0001_0000 -> product=64'h1_0000_0000.
REQ-032 Start during RUN: start pulsed at RUN cycle 10 with a=7, b=7 -> ignored; the original product is delivered and exactly one done pulse occurs.
REQ-033 Back-to-back: start held high through DONE with new a=2, b=9 -> second accept in the DONE cycle; product=18 appears 33 cycles later; the first product stays stable until then.
REQ-034 Reset mid-operation: rst at RUN cycle 20 -> next cycle busy=0, done=0, product=0; no done pulse follows; a fresh start then completes normally.

Source files
------------

// File: rtl/mul_seq_32_pkg.sv
// mul_seq_32 shared package: FSM state encoding and sizing constants.
// No ports; imported by mul_seq_32 and fulladd_64.
package mul_seq_32_pkg;

  localparam int OP_W   = 32;
  localparam int ITER   = 32;
  localparam int CNT_W  = 5;
  localparam int PROD_W = 2 * OP_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

endpackage

// File: rtl/fulladd_64.sv
// fulladd_64: 64-bit adder for the shift-add accumulator.
// Ports: a_i, b_i (64b addends) -> sum_o (64b, carry-out dropped).
module fulladd_64
  import mul_seq_32_pkg::*;
(
  input  logic [PROD_W-1:0] a_i,
  input  logic [PROD_W-1:0] b_i,
  output logic [PROD_W-1:0] sum_o
);

  // A 32x32 product never exceeds 64 bits, so the
  // carry out of bit 63 is simply not produced.
  assign sum_o = a_i + b_i;

endmodule

// File: rtl/mul_seq_32.sv
// mul_seq_32: 32x32 unsigned shift-add multiplier, 32 RUN cycles.
// Ports: clk, rst, start, a, b in; busy, done, product out.
module mul_seq_32
  import mul_seq_32_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  state_e              state_q, state_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [OP_W-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   product_q, product_d;
  logic [PROD_W-1:0]   sum;

  fulladd_64 u_add (
    .a_i   (acc_q),
    .b_i   (mcand_q),
    .sum_o (sum)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = {{(PROD_W-OP_W){1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Last iteration: publish the sum including
        // this cycle's partial product.
        if (cnt_q == CNT_LAST) begin
          product_d = acc_d;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule
